// File: rtl/rx_bit_unstuffer.sv
// Bit-stuff tracker for the USB RX path: counts runs of the stuffing polarity,
// flags the stuffed bit for removal and counts stuffing violations.
module rx_bit_unstuffer #(
    parameter int RUN_LEN   = 6,
    parameter int POLARITY  = 1,
    parameter int ERR_CNT_W = 8,
    parameter int CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 clear,
    input  logic                 clear_err,
    input  logic                 bit_valid,
    input  logic                 decoded_bit,
    output logic                 ignore_bit,
    output logic                 stuff_err,
    output logic [CNT_W-1:0]     run_count,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_SKIP = 1'b1;

    localparam logic             POL_BIT  = 1'(POLARITY);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_LEN - 1);

    logic [0:0]           state_q,     state_d;
    logic [CNT_W-1:0]     run_count_q, run_count_d;
    logic                 stuff_err_q, stuff_err_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
    logic                 violation_s;

    // The stuffed bit is dropped in the same cycle it arrives; a resync wins.
    assign ignore_bit = bit_valid & (state_q == ST_SKIP) & ~clear;
    assign stuff_err  = stuff_err_q;
    assign run_count  = run_count_q;
    assign err_count  = err_count_q;

    // Next-state logic for the run/skip tracker and the violation pulse.
    always_comb begin
        state_d     = state_q;
        run_count_d = run_count_q;
        stuff_err_d = 1'b0;
        violation_s = 1'b0;
        if (clear) begin
            state_d     = ST_RUN;
            run_count_d = {CNT_W{1'b0}};
        end else if (bit_valid) begin
            case (state_q)
                ST_RUN: begin
                    if (decoded_bit == POL_BIT) begin
                        if (run_count_q == RUN_LAST) begin
                            run_count_d = {CNT_W{1'b0}};
                            state_d     = ST_SKIP;
                        end else begin
                            run_count_d = run_count_q + CNT_W'(1);
                        end
                    end else begin
                        run_count_d = {CNT_W{1'b0}};
                    end
                end
                ST_SKIP: begin
                    // A violating bit is dropped too and never seeds a new run.
                    state_d     = ST_RUN;
                    run_count_d = {CNT_W{1'b0}};
                    if (decoded_bit == POL_BIT) begin
                        violation_s = 1'b1;
                        stuff_err_d = 1'b1;
                    end else begin
                        violation_s = 1'b0;
                    end
                end
                default: begin
                    state_d     = ST_RUN;
                    run_count_d = {CNT_W{1'b0}};
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Saturating violation counter; an explicit clear beats a same-cycle increment.
    always_comb begin
        err_count_d = err_count_q;
        if (clear_err) begin
            err_count_d = {ERR_CNT_W{1'b0}};
        end else if (violation_s && !(&err_count_q)) begin
            err_count_d = err_count_q + ERR_CNT_W'(1);
        end else begin
            err_count_d = err_count_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_RUN;
            run_count_q <= {CNT_W{1'b0}};
            stuff_err_q <= 1'b0;
            err_count_q <= {ERR_CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            run_count_q <= run_count_d;
            stuff_err_q <= stuff_err_d;
            err_count_q <= err_count_d;
        end
    end

endmodule
